// File: rtl/video_timing_pkg.sv
// video_timing_pkg: pattern encoding, standard mode timings and a clog2 helper
package video_timing_pkg;

    typedef enum logic [1:0] {PAT_BARS, PAT_GRAD, PAT_CHECK, PAT_SOLID} pattern_t;

    localparam int VGA640_CLK_DIV  = 4;
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;
    localparam bit VGA640_HS_POL   = 1'b0;
    localparam bit VGA640_VS_POL   = 1'b0;

    // 800x600@72 runs on a 50 MHz pixel clock with positive syncs
    localparam int SVGA800_CLK_DIV  = 2;
    localparam int SVGA800_H_ACTIVE = 800;
    localparam int SVGA800_H_FP     = 56;
    localparam int SVGA800_H_SYNC   = 120;
    localparam int SVGA800_H_BP     = 64;
    localparam int SVGA800_V_ACTIVE = 600;
    localparam int SVGA800_V_FP     = 37;
    localparam int SVGA800_V_SYNC   = 6;
    localparam int SVGA800_V_BP     = 23;
    localparam bit SVGA800_HS_POL   = 1'b1;
    localparam bit SVGA800_VS_POL   = 1'b1;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/video_timing_pattern_gen_rom.sv
// video_pattern_rom_free: combinational test-pattern colour for one pixel
module video_pattern_rom_free
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int CW       = 8
) (
    input  pattern_t      pat_sel,
    input  logic [11:0]   x,
    input  logic [11:0]   y,
    input  logic          de,
    output logic [CW-1:0] red,
    output logic [CW-1:0] green,
    output logic [CW-1:0] blue
);

    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0]    bar;
    logic [2:0]    rgb;
    logic [CW-1:0] grad;

    always_comb begin
        bar = '0;
        // the last bar keeps anything beyond 7*BAR_W, absorbing the remainder
        for (int i = 1; i < 8; i++) if (int'(x) >= i * BAR_W) bar = 3'(i);
        grad = CW'(x);
        rgb = pat_sel == PAT_BARS  ? {~bar[1], ~bar[2], ~bar[0]} :
              pat_sel == PAT_CHECK ? {3{1'((x ^ y) >> 5)}} : 3'b111;
        red   = !de ? '0 : pat_sel == PAT_GRAD ? grad : {CW{rgb[2]}};
        green = !de ? '0 : pat_sel == PAT_GRAD ? grad : {CW{rgb[1]}};
        blue  = !de ? '0 : pat_sel == PAT_GRAD ? grad : {CW{rgb[0]}};
    end

endmodule

// File: rtl/video_timing_pattern_gen.sv
// video_timing_pattern_gen: parametrised VGA/DVI timing with frame-synchronous pattern stepping
module video_timing_pattern_gen
    import video_timing_pkg::*;
#(
    parameter int CLK_DIV  = VGA640_CLK_DIV,
    parameter int H_ACTIVE = VGA640_H_ACTIVE,
    parameter int H_FP     = VGA640_H_FP,
    parameter int H_SYNC   = VGA640_H_SYNC,
    parameter int H_BP     = VGA640_H_BP,
    parameter int V_ACTIVE = VGA640_V_ACTIVE,
    parameter int V_FP     = VGA640_V_FP,
    parameter int V_SYNC   = VGA640_V_SYNC,
    parameter int V_BP     = VGA640_V_BP,
    parameter bit HS_POL   = VGA640_HS_POL,
    parameter bit VS_POL   = VGA640_VS_POL,
    parameter int CW       = 8
) (
    input  logic          CLK100,
    input  logic          btns,
    input  logic          pat_next,
    output logic          pix_ce,
    output logic          Hsync,
    output logic          Vsync,
    output logic          de,
    output logic [11:0]   x,
    output logic [11:0]   y,
    output logic [CW-1:0] red,
    output logic [CW-1:0] green,
    output logic [CW-1:0] blue,
    output logic          frame_start,
    output logic [1:0]    pat_sel
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = clog2(H_TOTAL);
    localparam int VW      = clog2(V_TOTAL);
    localparam int DW      = CLK_DIV > 1 ? clog2(CLK_DIV) : 1;

    logic [DW-1:0] div;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          pending;
    pattern_t      pat;
    pattern_t      pat_nx;
    logic          h_wrap;
    logic          v_wrap;
    logic          consume;
    logic          hs_on;
    logic          vs_on;
    logic          act;
    logic [CW-1:0] r_nx;
    logic [CW-1:0] g_nx;
    logic [CW-1:0] b_nx;

    // gated by btns so CLK_DIV=1 still shows pix_ce low during reset
    assign pix_ce  = div == DW'(CLK_DIV - 1) && !btns;
    assign pat_sel = pat;

    always_comb begin
        h_wrap  = hcnt == HW'(H_TOTAL - 1);
        v_wrap  = vcnt == VW'(V_TOTAL - 1);
        consume = pix_ce && hcnt == '0 && vcnt == '0;
        pat_nx  = consume && pending ? pattern_t'(pat + 2'd1) : pat;
        hs_on   = int'(hcnt) >= H_ACTIVE + H_FP && int'(hcnt) < H_ACTIVE + H_FP + H_SYNC;
        vs_on   = int'(vcnt) >= V_ACTIVE + V_FP && int'(vcnt) < V_ACTIVE + V_FP + V_SYNC;
        act     = int'(hcnt) < H_ACTIVE && int'(vcnt) < V_ACTIVE;
    end

    // colours for pixel (0,0) must already use the pattern being stepped to
    video_pattern_rom_free #(
        .H_ACTIVE(H_ACTIVE),
        .CW      (CW)
    ) u_rom (
        .pat_sel(pat_nx),
        .x      (12'(hcnt)),
        .y      (12'(vcnt)),
        .de     (act),
        .red    (r_nx),
        .green  (g_nx),
        .blue   (b_nx)
    );

    always_ff @(posedge CLK100 or posedge btns) begin
        if (btns) begin
            div         <= '0;
            hcnt        <= '0;
            vcnt        <= '0;
            pat         <= PAT_BARS;
            pending     <= 1'b0;
            Hsync       <= ~HS_POL;
            Vsync       <= ~VS_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            frame_start <= 1'b0;
        end else begin
            div         <= pix_ce ? '0 : div + 1'b1;
            pending     <= consume ? pat_next : pending | pat_next;
            frame_start <= consume;
            if (pix_ce) begin
                hcnt  <= h_wrap ? '0 : hcnt + 1'b1;
                if (h_wrap) vcnt <= v_wrap ? '0 : vcnt + 1'b1;
                pat   <= pat_nx;
                Hsync <= hs_on ? HS_POL : ~HS_POL;
                Vsync <= vs_on ? VS_POL : ~VS_POL;
                de    <= act;
                x     <= 12'(hcnt);
                y     <= 12'(vcnt);
                red   <= r_nx;
                green <= g_nx;
                blue  <= b_nx;
            end
        end
    end

endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// tb_video_timing_pattern_gen: scoreboard bench against a frame-arithmetic reference model
module tb_video_timing_pattern_gen;

    localparam int D   = 3;
    localparam int HA  = 64;
    localparam int HF  = 2;
    localparam int HSY = 4;
    localparam int HB  = 2;
    localparam int VA  = 40;
    localparam int VF  = 1;
    localparam int VSY = 2;
    localparam int VB  = 2;
    localparam int CW  = 5;
    localparam bit HSP = 1'b1;
    localparam bit VSP = 1'b0;
    localparam int HT  = HA + HF + HSY + HB;
    localparam int VT  = VA + VF + VSY + VB;
    localparam int FT  = HT * VT;
    localparam int MAX = (1 << CW) - 1;

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          de;
        logic [11:0]   x;
        logic [11:0]   y;
        logic [CW-1:0] r;
        logic [CW-1:0] g;
        logic [CW-1:0] b;
        logic          fs;
        logic [1:0]    pat;
    } px_t;

    logic          CLK100   = 1'b0;
    logic          btns     = 1'b0;
    logic          pat_next = 1'b0;
    logic          pix_ce, Hsync, Vsync, de, frame_start;
    logic [11:0]   x, y;
    logic [CW-1:0] red, green, blue;
    logic [1:0]    pat_sel;

    int   checks = 0;
    int   fails  = 0;
    px_t  sb[$];
    int   n      = 0;
    int   pat_m  = 0;
    int   k      = 0;
    bit   pend_m = 1'b0;
    bit   mon_en = 1'b0;
    bit   ce_seen = 1'b0;
    px_t  prev, cur, e;
    logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    video_timing_pattern_gen #(
        .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .HS_POL(HSP), .VS_POL(VSP), .CW(CW)
    ) dut (
        .CLK100(CLK100), .btns(btns), .pat_next(pat_next), .pix_ce(pix_ce),
        .Hsync(Hsync), .Vsync(Vsync), .de(de), .x(x), .y(y),
        .red(red), .green(green), .blue(blue),
        .frame_start(frame_start), .pat_sel(pat_sel)
    );

    always #5 CLK100 = ~CLK100;

    function automatic px_t outs();
        return {Hsync, Vsync, de, x, y, red, green, blue, frame_start, pat_sel};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // expected outputs for linear pixel index kk of a frame sequence under pattern p
    function automatic px_t pixel(input int kk, input int p);
        int  h, v, bar;
        int  c[3];
        px_t r;
        h     = kk % HT;
        v     = (kk / HT) % VT;
        r.hs  = (h >= HA + HF && h < HA + HF + HSY) ? HSP : !HSP;
        r.vs  = (v >= VA + VF && v < VA + VF + VSY) ? VSP : !VSP;
        r.de  = h < HA && v < VA;
        r.x   = 12'(h);
        r.y   = 12'(v);
        r.fs  = h == 0 && v == 0;
        r.pat = 2'(p);
        bar   = h / (HA / 8);
        if (bar > 7) bar = 7;
        case (p)
            0: for (int i = 0; i < 3; i++) c[i] = bar_tab[bar][23-8*i -: 8] != 0 ? MAX : 0;
            1: c = '{h % (1 << CW), h % (1 << CW), h % (1 << CW)};
            2: c = ((h / 32 + v / 32) % 2) != 0 ? '{MAX, MAX, MAX} : '{0, 0, 0};
            default: c = '{MAX, MAX, MAX};
        endcase
        if (!r.de) c = '{0, 0, 0};
        r.r = CW'(c[0]);
        r.g = CW'(c[1]);
        r.b = CW'(c[2]);
        return r;
    endfunction

    // reference model: n = clock edges since reset release; every D-th edge shows pixel n/D-1
    always @(posedge CLK100) begin
        if (btns) begin
            n      = 0;
            pat_m  = 0;
            pend_m = 1'b0;
            sb.delete();
        end else begin
            n++;
            if (n % D == 0) begin
                k = n / D - 1;
                if (k % FT == 0) begin
                    pat_m  = (pat_m + int'(pend_m)) % 4;
                    pend_m = pat_next;
                end else pend_m = pend_m | pat_next;
                sb.push_back(pixel(k, pat_m));
            end else pend_m = pend_m | pat_next;
        end
    end

    always @(negedge CLK100) begin
        #2;
        if (mon_en) chk("pix_ce", 64'(pix_ce), 64'(!btns && (n + 1) % D == 0));
        ce_seen = pix_ce;
        prev    = outs();
    end

    always @(posedge CLK100) begin
        #1;
        if (mon_en) begin
            cur = outs();
            if (ce_seen) begin
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL sb_underflow: DUT output x=%0d y=%0d, expected nothing", x, y);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("pixel(%0d,%0d)", e.x, e.y), 64'(cur), 64'(e));
                end
            end else begin
                e    = prev;
                e.fs = 1'b0;
                chk("hold", 64'(cur), 64'(e));
            end
        end
    end

    initial begin
        px_t rv;
        int  cnt;
        rv    = '0;
        rv.hs = !HSP;
        rv.vs = !VSP;
        #20 btns = 1'b1;
        #2 mon_en = 1'b1;
        #18;
        chk("reset_outputs", 64'(outs()), 64'(rv));
        chk("reset_pix_ce", 64'(pix_ce), 64'(0));
        #60 btns = 1'b0;
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(500, 2500)) @(negedge CLK100);
            pat_next = 1'b1;
            @(negedge CLK100);
            pat_next = 1'b0;
        end
        chk("pat_before_frame1", 64'(pat_sel), 64'(0));
        cnt = 0;
        while (!((n + 1) % D == 0 && ((n + 1) / D - 1) % FT == 0 && (n + 1) / D > 1) && cnt < 3 * FT * D) begin
            @(negedge CLK100);
            cnt++;
        end
        chk("frame1_boundary_found", 64'(cnt < 3 * FT * D), 64'(1));
        pat_next = 1'b1;
        @(negedge CLK100);
        pat_next = 1'b0;
        chk("pat_frame1", 64'(pat_sel), 64'(1));
        chk("fs_frame1", 64'(frame_start), 64'(1));
        repeat (FT * D + 2000) @(negedge CLK100);
        chk("pat_frame2", 64'(pat_sel), 64'(2));
        pat_next = 1'b1;
        @(negedge CLK100);
        pat_next = 1'b0;
        repeat (FT * D) @(negedge CLK100);
        chk("pat_frame3", 64'(pat_sel), 64'(3));
        cnt = 0;
        do begin
            @(posedge CLK100);
            #2;
            cnt++;
        end while (Hsync !== HSP && cnt < 2 * HT * D);
        chk("hsync_asserted_before_reset", 64'(Hsync), 64'(HSP));
        btns = 1'b1;
        #1;
        chk("async_reset_outputs", 64'(outs()), 64'(rv));
        chk("async_reset_pix_ce", 64'(pix_ce), 64'(0));
        @(negedge CLK100);
        @(negedge CLK100);
        btns = 1'b0;
        cnt  = 0;
        while (cnt < 20) begin
            @(posedge CLK100);
            #1;
            cnt++;
            if (frame_start) break;
        end
        chk("fs_latency_after_release", 64'(cnt), 64'(D));
        repeat (2 * FT * D) begin
            @(negedge CLK100);
            pat_next = $urandom_range(0, 1999) == 0;
        end
        pat_next = 1'b0;
        repeat (10) @(negedge CLK100);
        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/video_timing_pattern_gen.md
Name: video_timing_pattern_gen

Overview:
- Parametrised successor to the fixed-mode Nexys3 video path.
- Runs on the board's 100 MHz clock and derives a pixel clock-enable from it.
- Generates fully parametrised VGA/DVI timing (Hsync, Vsync, data-enable, pixel coordinates) and a selectable test pattern.
- The pattern can be stepped at run time, with the change deferred to a frame boundary; outputs feed the VGA pins and the TMDS encoder.

Parameters:
- CLK_DIV, 4: CLK100 cycles per pixel (4 gives 25 MHz, 640x480@60); legal range 1..16.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- HS_POL, 0: asserted level of Hsync.
- VS_POL, 0: asserted level of Vsync.
- CW, 8: bits per colour channel.

Ports:
- CLK100  in  1  system clock, 100 MHz.
- btns  in  1  reset; asynchronous, active-high.
- pat_next  in  1  single-cycle request to advance the pattern; already synchronised and debounced.
- pix_ce  out  1  pixel clock-enable.
- Hsync  out  1  horizontal sync.
- Vsync  out  1  vertical sync.
- de  out  1  active-video flag.
- x  out  12  pixel column (0..H_ACTIVE-1 while de is high).
- y  out  12  pixel line (0..V_ACTIVE-1 while de is high).
- red  out  CW  red channel.
- green  out  CW  green channel.
- blue  out  CW  blue channel.
- frame_start  out  1  one-cycle pulse on the first pixel of a frame.
- pat_sel  out  2  currently applied pattern.

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. Counter width is clog2 of each total.
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - pix_ce = (div == CLK_DIV-1).
  - CLK_DIV=1 gives pix_ce constantly high.
- Counters advance only on pix_ce.
  - hcnt wraps from H_TOTAL-1 to 0.
  - vcnt increments when hcnt wraps, and itself wraps from V_TOTAL-1 to 0.
- Output registration: Hsync, Vsync, de, x, y, colours and frame_start are registered from counter state on pix_ce cycles. Fixed latency is one pixel (CLK_DIV clocks). Between pix_ce cycles they hold their values; frame_start holds 0.
- Hsync = HS_POL while hcnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; otherwise ~HS_POL.
- Vsync is defined the same way on vcnt, using VS_POL. It changes together with the hcnt=0 pixel.
- de = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
  - x and y are zero-extended hcnt and vcnt.
  - While de is low, x and y keep counting and colours are forced to 0.
- frame_start is high for exactly one CLK100 cycle, coincident with the output registers showing pixel (0,0).
- Patterns, by pat_sel (colour level MAX = 2^CW-1):
  - 0, colour bars: 8 vertical bars, each H_ACTIVE/8 wide (integer division); the last bar absorbs the remainder. Order: white, yellow, cyan, green, magenta, red, blue, black. Each channel is 0 or MAX.
  - 1, gradient: red = green = blue = x[CW-1:0] (wraps on overflow).
  - 2, checkerboard: MAX on all channels when x[5]^y[5] is 1, else 0 (32-pixel squares).
  - 3, solid: MAX on all channels.
- Pattern stepping:
  - pat_next sets a pending flag.
  - The flag is consumed on the pix_ce at which counters are (0,0): pat_sel increments, wrapping 3 to 0, and the frame starting there uses the new pattern.
  - Any number of requests within one frame coalesces into a single step.
  - A pat_next arriving in the same cycle the flag is consumed re-arms the flag for the next frame.
- Reset (btns high, asynchronous): div, hcnt, vcnt, pat_sel and the pending flag go to 0. Outputs go to: pix_ce=0, Hsync=~HS_POL, Vsync=~VS_POL, de=0, x=0, y=0, colours 0, frame_start=0.
- On reset release: the first pix_ce comes CLK_DIV cycles later, and its registered output is pixel (0,0) with frame_start asserted.
- Reset asserted mid-frame aborts immediately; there is no partial-state retention.

Decomposition:
- Package video_timing_pkg holds:
  - pattern enumeration (PAT_BARS, PAT_GRAD, PAT_CHECK, PAT_SOLID);
  - the mode timing constants for 640x480@60 (CLK_DIV 4) and 800x600@72 (CLK_DIV 2);
  - a clog2 function.
- One natural sub-module, video_pattern_rom_free: a purely combinational colour function of (pat_sel, x, y, de). Everything else stays in the top.

Test Plan:
1. Default parameters, btns pulsed from 20 ns to 100 ns. Required response:
   - pix_ce period is 40 ns.
   - Hsync is low for 384 CLK100 cycles, every 3200 cycles.
   - Vsync is low for 2 lines (6400 cycles).
   - frame_start period is 1,680,000 cycles.
   - de is high for 640 of every 800 pixels.
2. Small mode (H_ACTIVE 8, H_FP 1, H_SYNC 2, H_BP 1, V_ACTIVE 4, V_FP 1, V_SYNC 1, V_BP 1, CLK_DIV 1, HS_POL 1). Required response:
   - Hsync is high on hcnt 9..10.
   - Line length is 12 clocks; frame length is 84 clocks.
   - Colour bars are one pixel wide, in order FFFFFF, FFFF00 ... 000000.
3. Three pat_next pulses mid-frame. Required response: pat_sel stays 0 until the next frame_start, then becomes 1. A further pulse coincident with frame_start yields pat_sel 2 at the following frame.
4. Gradient pattern, CW 8. Required response: red = green = blue = x mod 256; x=300 gives 44. Colours are 0 while de is low.
5. btns asserted mid-line with Hsync asserted. Required response: Hsync returns to ~HS_POL asynchronously, and all outputs take their reset values within the same cycle. After release, frame_start occurs CLK_DIV cycles later.
6. CLK_DIV=3 with the checkerboard pattern. Required response:
   - pix_ce is high 1 cycle in 3, and outputs are stable across the other 2.
   - Pixel (32,0) is white and (32,32) is black.
